// File: rtl/ctrl_unit_param.sv
// FETCH/EXECUTE control unit: 2 cycles per instruction, LOAD/STORE add one cycle per MEM_WAIT cycle up to the ack.
// Stalls in MEM_WAIT, holding mem_req/mem_we/mem_addr/mem_wdata stable, until mem_ack; HALT holds until reset.
module ctrl_unit_param #(
    parameter int DW    = 8,
    parameter int PCW   = 12,
    parameter int NPORT = 2
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [15:0]         instruction,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mem_ack,
    input  logic [DW-1:0]       alu_result,
    input  logic                alu_equal,
    input  logic                alu_carry,
    input  logic [NPORT*DW-1:0] in_gpio,
    input  logic                bootstrapping,
    output logic [2:0]          alu_opcode,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic                mem_req,
    output logic                mem_we,
    output logic [7:0]          mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic                pc_inc,
    output logic                pc_load,
    output logic [PCW-1:0]      pc_next,
    output logic [NPORT*DW-1:0] out_gpio,
    output logic [NPORT-1:0]    out_strobe,
    output logic [1:0]          state,
    output logic                halted
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXECUTE  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BC    = 4'h5;
    localparam logic [3:0] OP_IN    = 4'h6;
    localparam logic [3:0] OP_OUT   = 4'h7;
    localparam logic [3:0] P_MASK   = 4'(NPORT - 1);

    state_t                state_q, state_d;
    logic [15:0]           instr_q, instr_d;
    logic [DW-1:0]         regs_q [16];
    logic [DW-1:0]         regs_d [16];
    logic                  z_q, z_d, c_q, c_d;
    logic [NPORT*DW-1:0]   gpio_hold_q, gpio_hold_d;
    logic [2:0]            alu_opcode_q, alu_opcode_d;
    logic [DW-1:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [7:0]            mem_addr_q, mem_addr_d;
    logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
    logic                  pc_load_q, pc_load_d;
    logic [PCW-1:0]        pc_next_q, pc_next_d;
    logic [NPORT*DW-1:0]   out_gpio_q, out_gpio_d;
    logic [NPORT-1:0]      out_strobe_q, out_strobe_d;

    logic [3:0] opcode, dst, port_idx;

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        z_d          = z_q;
        c_d          = c_q;
        gpio_hold_d  = gpio_hold_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pc_next_d    = pc_next_q;
        out_gpio_d   = out_gpio_q;
        pc_load_d    = 1'b0;
        out_strobe_d = '0;
        opcode       = instr_q[15:12];
        dst          = instr_q[11:8];
        port_idx     = instr_q[3:0] & P_MASK;

        case (state_q)
            S_FETCH: begin
                instr_d      = instruction;
                alu_a_d      = regs_q[instruction[7:4]];
                alu_b_d      = regs_q[instruction[3:0]];
                alu_opcode_d = instruction[14:12];
                mem_addr_d   = instruction[7:0];
                mem_wdata_d  = regs_q[instruction[11:8]];
                gpio_hold_d  = in_gpio;
                state_d      = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: begin
                        if (instr_q[11:0] == 12'hFFF) state_d = S_HALT;
                    end
                    OP_LOAD: begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = S_MEM_WAIT;
                    end
                    OP_STORE: begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        state_d   = S_MEM_WAIT;
                    end
                    OP_JMP: begin
                        pc_next_d = instr_q[PCW-1:0];
                        pc_load_d = 1'b1;
                    end
                    OP_BEQ: begin
                        if (z_q) begin
                            pc_next_d = instr_q[PCW-1:0];
                            pc_load_d = 1'b1;
                        end
                    end
                    OP_BC: begin
                        if (c_q) begin
                            pc_next_d = instr_q[PCW-1:0];
                            pc_load_d = 1'b1;
                        end
                    end
                    OP_IN: begin
                        if (bootstrapping) begin
                            regs_d[dst] = DW'(instr_q[7:0]);
                        end else begin
                            for (int p = 0; p < NPORT; p++) begin
                                if (port_idx == 4'(p)) regs_d[dst] = gpio_hold_q[p*DW +: DW];
                            end
                        end
                    end
                    OP_OUT: begin
                        for (int p = 0; p < NPORT; p++) begin
                            if (port_idx == 4'(p)) begin
                                out_gpio_d[p*DW +: DW] = regs_q[dst];
                                out_strobe_d[p]        = 1'b1;
                            end
                        end
                    end
                    default: begin
                        regs_d[dst] = alu_result;
                        z_d         = alu_equal;
                        c_d         = alu_carry;
                    end
                endcase
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    if (!mem_we_q) regs_d[dst] = mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_FETCH;
            instr_q      <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            z_q          <= 1'b0;
            c_q          <= 1'b0;
            gpio_hold_q  <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            out_gpio_q   <= '0;
            out_strobe_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            regs_q       <= regs_d;
            z_q          <= z_d;
            c_q          <= c_d;
            gpio_hold_q  <= gpio_hold_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            pc_load_q    <= pc_load_d;
            pc_next_q    <= pc_next_d;
            out_gpio_q   <= out_gpio_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign out_gpio   = out_gpio_q;
    assign out_strobe = out_strobe_q;
    assign state      = state_q;
    assign pc_inc     = (state_q == S_FETCH);
    assign halted     = (state_q == S_HALT);

endmodule

// File: doc/ctrl_unit_param.md
# ctrl_unit_param

Parametrised two-operand microcontroller control unit for the uC datapath: decodes 16-bit instructions from program ROM, owns the 16-entry register file, drives the external ALU, the PC, a request/acknowledge data-SRAM port and NPORT GPIO ports. It extends the FETCH/EXECUTE sequencer with:

- configurable data and PC widths;
- registered Z/C flags;
- a wait-state memory handshake;
- multi-port GPIO with write strobes;
- a HALT state.

## Interface
Parameters:
- DW, 8, data/register width (≥8)
- PCW, 12, program counter width (1..12)
- NPORT, 2, GPIO port count (power of two, 1..16)

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- instruction  in  16  current ROM word: opcode[15:12], dst[11:8], a[7:4], b[3:0]
- mem_rdata  in  DW  SRAM read data, valid with mem_ack
- mem_ack  in  1  SRAM transfer complete
- alu_result  in  DW  ALU result
- alu_equal, alu_carry  in  1 each  ALU status
- in_gpio  in  NPORT*DW  input ports, port p at [p*DW +: DW]
- bootstrapping  in  1  IN loads immediate instead of port
- alu_opcode  out  3  ALU op
- alu_a, alu_b  out  DW each  ALU operands
- mem_req  out  1  SRAM request
- mem_we  out  1  1 = write
- mem_addr  out  8  SRAM address
- mem_wdata  out  DW  SRAM write data
- pc_inc  out  1  advance PC
- pc_load  out  1  load pc_next, 1-cycle pulse
- pc_next  out  PCW  branch target
- out_gpio  out  NPORT*DW  output port registers
- out_strobe  out  NPORT  1-cycle write pulse per port
- state  out  2  FSM state
- halted  out  1  HALT reached

## Operation
- **States:** FETCH=0, EXECUTE=1, MEM_WAIT=2, HALT=3.
- **FETCH:**
  - latch instruction fields;
  - alu_a←R[a], alu_b←R[b], alu_opcode←instruction[14:12];
  - mem_addr←{a,b}, mem_wdata←R[dst];
  - sample in_gpio into a holding register;
  - →EXECUTE.
- **EXECUTE**, by opcode:
  - 0 NOP: if instruction[11:0]==12'hFFF this is HALT, →HALT; otherwise no effect.
  - 1 LOAD: mem_req←1, mem_we←0, →MEM_WAIT.
  - 2 STORE: mem_req←1, mem_we←1, →MEM_WAIT.
  - 3 JMP: pc_next←instruction[PCW-1:0], pc_load←1.
  - 4 BEQ: as JMP only if flag Z=1.
  - 5 BC: as JMP only if flag C=1.
  - 6 IN: R[dst]←bootstrapping ? zero-extended {a,b} : held in_gpio of port (b mod NPORT).
  - 7 OUT: port (b mod NPORT) ← R[dst]; its out_strobe←1.
  - 8–15 ALU: R[dst]←alu_result, Z←alu_equal, C←alu_carry.
  - Every opcode except LOAD, STORE and HALT returns to FETCH.
- **Flags Z/C:** change only on ALU ops; persist across all other instructions.
- **MEM_WAIT:**
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - On ack: LOAD writes R[dst]←mem_rdata; mem_req←0; →FETCH.
  - Ack is ignored in every other state.
- **HALT:** absorbing; pc_inc=0; halted=1; only reset exits.
- **Register file:** register writes occur only in EXECUTE or on the MEM_WAIT ack cycle, so the next FETCH always reads the updated value (no forwarding needed).

## Timing
- **Reset values (async):**
  - state=FETCH;
  - all R[i]=0, Z=C=0;
  - all outputs 0: mem_req, mem_we, pc_load, out_strobe, out_gpio, alu_*, mem_addr, mem_wdata, pc_next, halted.
- **Combinational outputs:**
  - pc_inc = (state==FETCH): exactly one cycle per instruction.
  - halted = (state==HALT).
- **Cycle counts:**
  - Non-memory instruction: 2 cycles.
  - LOAD/STORE: 2 + N cycles, where N≥1 is the number of MEM_WAIT cycles up to and including the ack cycle.
  - mem_req rises at the start of the first MEM_WAIT cycle; ack in that same cycle gives the minimum of 3 cycles.
- **Pulse outputs:**
  - pc_load and out_strobe are high for exactly the cycle after EXECUTE, then cleared.
  - PC must apply pc_load before honouring the following pc_inc.
- **Reset mid-operation:**
  - reset during MEM_WAIT drops mem_req immediately;
  - the pending LOAD is not written.

## Test plan
- Reset, then IN with bootstrapping=1, instruction 16'h6312 → R3=8'h12 after 2 cycles; pc_inc high 1 of 2 cycles.
- ALU op with alu_equal=1, then a NOP, then BEQ 16'h4ABC → pc_load pulse, pc_next=12'hABC (Z persisted across the NOP); repeat with alu_equal=0 → no pc_load.
- LOAD 16'h1504, ack delayed 3 cycles, mem_rdata=8'h5A:
  - mem_req high 3 cycles, mem_addr=8'h04;
  - R5=8'h5A;
  - instruction takes 5 cycles.
- STORE with R2=8'hC3, immediate ack → mem_we=1, mem_wdata=8'hC3 for 1 cycle; no register changes.
- OUT 16'h7201 (NPORT=2), R2=8'h77:
  - out_gpio[15:8]=8'h77, out_strobe=2'b10 for one cycle;
  - port 0 unchanged.
- Instruction 16'h0FFF → halted=1, pc_inc stays 0, mem_ack ignored; async reset returns to FETCH with all outputs 0.
